// File: rtl/atsc_dc_blocker.sv
// atsc_dc_blocker: subtracts a 2^LOG2_LEN-sample running mean from each
// sample, saturating the result to 32 bits signed.
//
// Ports:
//   ce_clk, ce_rst          clock, synchronous active-high reset
//   bypass                  1: forward input unchanged (mean still updates)
//   in_tdata/tvalid/tlast   AXI-Stream input, in_tready back-pressure
//   out_tdata/tvalid/tlast  AXI-Stream output (one register stage),
//                           out_tready from downstream
module atsc_dc_blocker #(
  parameter int LOG2_LEN = 6
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        bypass,
  input  logic [31:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic        in_tlast,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast
);

  localparam int N  = 1 << LOG2_LEN;
  localparam int SW = 32 + LOG2_LEN;
  localparam logic [LOG2_LEN:0] FULL =
    {1'b1, {LOG2_LEN{1'b0}}};

  logic [31:0]          r_mem [N];
  logic signed [SW-1:0] r_sum;
  logic [LOG2_LEN-1:0]  r_wr_ptr;
  logic [LOG2_LEN:0]    r_fill_cnt;
  logic [31:0]          r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;

  logic                 w_accept;
  logic [31:0]          w_old;
  logic signed [SW-1:0] w_x_ext;
  logic signed [SW-1:0] w_old_ext;
  logic signed [SW-1:0] w_sum_nxt;
  logic signed [SW-1:0] w_mean;
  logic signed [SW-1:0] w_diff;
  logic [SW-32:0]       w_hi;
  logic                 w_fits;
  logic [31:0]          w_sat;

  assign in_tready = ~r_out_valid | out_tready;
  assign w_accept  = in_tvalid & in_tready;

  // Until the line has wrapped once, the slot being overwritten
  // holds stale data from before reset; treat it as zero.
  assign w_old = (r_fill_cnt == FULL) ? r_mem[r_wr_ptr] : 32'd0;

  assign w_x_ext   = {{LOG2_LEN{in_tdata[31]}}, in_tdata};
  assign w_old_ext = {{LOG2_LEN{w_old[31]}}, w_old};
  assign w_sum_nxt = r_sum + w_x_ext - w_old_ext;
  assign w_mean    = w_sum_nxt >>> LOG2_LEN;
  assign w_diff    = w_x_ext - w_mean;

  // Result fits in 32 bits when bits [SW-1:31] are all equal.
  assign w_hi   = w_diff[SW-1:31];
  assign w_fits = (&w_hi) | ~(|w_hi);
  assign w_sat  = w_fits ? w_diff[31:0] :
                  (w_diff[SW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);

  // Delay line: no reset, read-before-write through the async read.
  always_ff @(posedge ce_clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= in_tdata;
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_sum       <= w_sum_nxt;
      r_wr_ptr    <= r_wr_ptr + LOG2_LEN'(1);
      if (r_fill_cnt != FULL) begin
        r_fill_cnt <= r_fill_cnt + (LOG2_LEN+1)'(1);
      end
      r_out_data  <= bypass ? in_tdata : w_sat;
      r_out_valid <= 1'b1;
      r_out_last  <= in_tlast;
    end else if (out_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_tdata  = r_out_data;
  assign out_tvalid = r_out_valid;
  assign out_tlast  = r_out_last;

endmodule

// File: tb/tb_atsc_dc_blocker.sv
// tb_atsc_dc_blocker: vector table, hand sequences and random
// traffic against an arithmetic running-mean reference.
module tb_atsc_dc_blocker;

  localparam int L = 2;
  localparam int N = 4;

  logic        ce_clk;
  logic        ce_rst;
  logic        bypass;
  logic [31:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic        in_tlast;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;

  atsc_dc_blocker #(.LOG2_LEN(L)) dut (
    .ce_clk     (ce_clk),
    .ce_rst     (ce_rst),
    .bypass     (bypass),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tlast   (in_tlast),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast)
  );

  initial ce_clk = 1'b0;
  always #5 ce_clk = ~ce_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  typedef struct {
    bit          rst;
    logic [31:0] x;
    bit          byp;
    bit          last;
    logic [31:0] exp;
  } vec_t;

  exp_t   expq[$];
  longint hist[$];
  exp_t   mon_e;
  int     seg_cnt;
  int     seg_last_pos;
  int     seg_last_n;
  bit     rnd_done;
  logic [31:0] held;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t",
               nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference: output = x - floor(mean of last N accepted inputs).
  function automatic logic [31:0] model(input logic [31:0] x,
                                        input logic byp);
    longint xs;
    longint s;
    longint m;
    longint d;
    xs = longint'($signed(x));
    hist.push_back(xs);
    if (hist.size() > N) void'(hist.pop_front());
    s = 0;
    foreach (hist[k]) s += hist[k];
    if (s >= 0) m = s / N;
    else m = -((-s + N - 1) / N);
    d = xs - m;
    if (byp) return x;
    if (d > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (d < -64'sd2147483648) return 32'h8000_0000;
    return d[31:0];
  endfunction

  always @(negedge ce_clk) begin
    if (ce_rst) begin
      hist.delete();
      expq.delete();
    end else begin
      if (out_tvalid === 1'b1 && out_tready) begin
        seg_cnt++;
        if (out_tlast) begin
          seg_last_pos = seg_cnt;
          seg_last_n++;
        end
        if (expq.size() == 0) begin
          fail_now("sb_unexpected_output");
        end else begin
          mon_e = expq.pop_front();
          chk("sb_data", out_tdata, mon_e.d);
          chk("sb_last", {31'd0, out_tlast}, {31'd0, mon_e.l});
        end
      end
      if (in_tvalid && in_tready) begin
        mon_e.d = model(in_tdata, bypass);
        mon_e.l = in_tlast;
        expq.push_back(mon_e);
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic byp,
                      input logic last);
    logic acc;
    int   n;
    n = 0;
    in_tdata  = x;
    bypass    = byp;
    in_tlast  = last;
    in_tvalid = 1'b1;
    do begin
      @(negedge ce_clk);
      acc = in_tready;
      @(posedge ce_clk);
      #1;
      n++;
    end while (!acc && n < 200);
    in_tvalid = 1'b0;
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic do_reset();
    in_tvalid = 1'b0;
    ce_rst    = 1'b1;
    @(posedge ce_clk);
    #1;
    ce_rst = 1'b0;
    chk("rst_valid", {31'd0, out_tvalid}, 32'd0);
    chk("rst_data", out_tdata, 32'd0);
    chk("rst_last", {31'd0, out_tlast}, 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ce_rst     = 1'b1;
    bypass     = 1'b0;
    in_tdata   = '0;
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    out_tready = 1'b1;
    seg_cnt    = 0;
    seg_last_pos = 0;
    seg_last_n = 0;
    rnd_done   = 1'b0;

    tbl.push_back('{1, 32'd1000, 0, 0, 32'd750});
    tbl.push_back('{0, 32'd1000, 0, 0, 32'd500});
    tbl.push_back('{0, 32'd1000, 0, 1, 32'd250});
    tbl.push_back('{0, 32'd1000, 0, 0, 32'd0});
    tbl.push_back('{0, 32'd1000, 0, 0, 32'd0});
    tbl.push_back('{0, 32'd1000, 0, 0, 32'd0});
    tbl.push_back('{1, 32'hFFFF_FFFF, 0, 0, 32'd0});
    tbl.push_back('{0, 32'hFFFF_FFFF, 0, 0, 32'd0});
    tbl.push_back('{0, 32'hFFFF_FFFF, 0, 1, 32'd0});
    tbl.push_back('{0, 32'hFFFF_FFFF, 0, 0, 32'd0});
    tbl.push_back('{0, 32'hFFFF_FFFF, 0, 0, 32'd0});
    tbl.push_back('{0, 32'hFFFF_FFFF, 0, 0, 32'd0});
    tbl.push_back('{1, 32'h8000_0000, 0, 0, 32'hA000_0000});
    tbl.push_back('{0, 32'h8000_0000, 0, 0, 32'hC000_0000});
    tbl.push_back('{0, 32'h8000_0000, 0, 0, 32'hE000_0000});
    tbl.push_back('{0, 32'h7FFF_FFFF, 0, 1, 32'h7FFF_FFFF});
    tbl.push_back('{1, 32'd1000, 1, 0, 32'd1000});
    tbl.push_back('{0, 32'd1000, 1, 0, 32'd1000});
    tbl.push_back('{0, 32'd1000, 1, 0, 32'd1000});
    tbl.push_back('{0, 32'd1000, 1, 0, 32'd1000});
    tbl.push_back('{0, 32'd1000, 0, 1, 32'd0});

    do_reset();

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].x, tbl[i].byp, tbl[i].last);
      chk($sformatf("vec%0d_data", i), out_tdata, tbl[i].exp);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_tvalid}, 32'd1);
      chk($sformatf("vec%0d_last", i), {31'd0, out_tlast},
          {31'd0, tbl[i].last});
    end

    // Mid-stream reset restarts averaging from empty.
    do_reset();
    repeat (8) send(32'd1000, 1'b0, 1'b0);
    do_reset();
    send(32'd1000, 1'b0, 1'b0);
    chk("rst_restart", out_tdata, 32'd750);

    // Back-pressure: 16 samples, 10-cycle stall, tlast on sample 8.
    do_reset();
    seg_cnt      = 0;
    seg_last_pos = 0;
    seg_last_n   = 0;
    fork
      begin
        for (int i = 1; i <= 16; i++)
          send(32'(i * 37), 1'b0, i == 8);
      end
      begin
        repeat (4) @(posedge ce_clk);
        #1;
        out_tready = 1'b0;
        held = out_tdata;
        repeat (10) begin
          @(negedge ce_clk);
          chk("stall_ready", {31'd0, in_tready}, 32'd0);
          chk("stall_valid", {31'd0, out_tvalid}, 32'd1);
          chk("stall_hold", out_tdata, held);
        end
        @(posedge ce_clk);
        #1;
        out_tready = 1'b1;
      end
    join
    repeat (3) @(posedge ce_clk);
    #1;
    chk("stall_count", seg_cnt, 32'd16);
    chk("stall_nlast", seg_last_n, 32'd1);
    chk("stall_lastpos", seg_last_pos, 32'd8);

    // Random traffic against the reference model.
    do_reset();
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [31:0] x;
          case (i % 3)
            0: x = $urandom;
            1: x = 32'd1000 + 32'($urandom_range(0, 200)) - 32'd100;
            default: x = ($urandom_range(0, 1) != 0) ?
                         32'h7FFF_FFF0 + 32'($urandom_range(0, 15)) :
                         32'h8000_0000 + 32'($urandom_range(0, 15));
          endcase
          send(x, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0);
          repeat ($urandom_range(0, 2)) begin
            @(posedge ce_clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge ce_clk);
          #1;
          out_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_tready = 1'b1;
    repeat (4) @(posedge ce_clk);
    #1;
    chk("drain_empty", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
